// File: rtl/avalon_xor_dma.sv
// avalon_xor_dma: register-programmed XOR copy engine.
// The CPU programs KEY[0..KEY_WORDS-1], SRC, DST and NUM through the Avalon-MM
// target port, then writes START to CTRL. Each source word is read through the
// Avalon-MM initiator, XORed with KEY[idx % KEY_WORDS], and written to DST.
// A maskable level IRQ reports completion. ABORT stops after the current transfer.
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   avs_write/avs_writedata/avs_address target register writes; avs_readdata is combinational
//   avm_read/avm_write/avm_address/avm_writedata  initiator requests (registered)
//   avm_readdata, avm_waitrequest      initiator response and stall
//   irq                                DONE & IRQ_EN
module avalon_xor_dma #(
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [ADDR_W-1:0] avs_address,
  output logic [31:0]       avs_readdata,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_address,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              irq
);

  localparam int unsigned KI_W     = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int unsigned IDX_SRC  = KEY_WORDS;
  localparam int unsigned IDX_DST  = KEY_WORDS + 1;
  localparam int unsigned IDX_NUM  = KEY_WORDS + 2;
  localparam int unsigned IDX_CTRL = KEY_WORDS + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [KI_W-1:0]  KI_ONE  = KI_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       key_q [KEY_WORDS];
  logic [31:0]       key_d [KEY_WORDS];
  logic [31:0]       src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  num_q, num_d, idx_q, idx_d;
  logic [KI_W-1:0]   kidx_q, kidx_d;
  logic [31:0]       src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic              irq_en_q, irq_en_d, done_q, done_d;
  logic              aborted_q, aborted_d, abort_pend_q, abort_pend_d;
  logic              avm_read_q, avm_read_d, avm_write_q, avm_write_d;
  logic [31:0]       avm_address_q, avm_address_d, avm_writedata_q, avm_writedata_d;

  logic [31:0] reg_num;
  logic [31:0] cnt32;
  logic [31:0] key_sel;
  logic        busy, cfg_wr, ctrl_wr, start, abort_req, abort_now;
  logic        unused_addr_lsb;

  assign reg_num         = 32'(avs_address[ADDR_W-1:2]);
  assign cnt32           = 32'(idx_q);
  assign unused_addr_lsb = ^avs_address[1:0];
  assign busy            = (state_q == S_RD) || (state_q == S_WR);

  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign irq           = done_q & irq_en_q;

  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    src_d           = src_q;
    dst_d           = dst_q;
    num_d           = num_q;
    idx_d           = idx_q;
    kidx_d          = kidx_q;
    src_ptr_d       = src_ptr_q;
    dst_ptr_d       = dst_ptr_q;
    irq_en_d        = irq_en_q;
    done_d          = done_q;
    aborted_d       = aborted_q;
    abort_pend_d    = abort_pend_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;

    key_sel = '0;
    for (int unsigned i = 0; i < KEY_WORDS; i++)
      if (32'(kidx_q) == i) key_sel = key_q[i];

    cfg_wr    = avs_write && !busy;
    ctrl_wr   = avs_write && (reg_num == IDX_CTRL);
    start     = ctrl_wr && avs_writedata[0] && (state_q == S_IDLE);
    abort_req = ctrl_wr && avs_writedata[3] && busy;
    abort_now = abort_pend_q || abort_req;

    if (cfg_wr) begin
      for (int unsigned i = 0; i < KEY_WORDS; i++)
        if (reg_num == i) key_d[i] = avs_writedata;
      if (reg_num == IDX_SRC) src_d = avs_writedata;
      if (reg_num == IDX_DST) dst_d = avs_writedata;
      if (reg_num == IDX_NUM) num_d = avs_writedata[CNT_W-1:0];
    end

    if (ctrl_wr) begin
      irq_en_d = avs_writedata[1];
      if (avs_writedata[2]) done_d = 1'b0;
      if (avs_writedata[4]) aborted_d = 1'b0;
    end
    if (abort_req) abort_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d    = src_q;
          dst_ptr_d    = dst_q;
          idx_d        = '0;
          kidx_d       = '0;
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          if (num_q == '0) begin
            state_d = S_FIN;
          end else begin
            state_d       = S_RD;
            avm_read_d    = 1'b1;
            avm_address_d = src_q;
          end
        end
      end
      S_RD: begin
        if (!avm_waitrequest) begin
          avm_read_d      = 1'b0;
          avm_writedata_d = avm_readdata ^ key_sel;
          if (abort_now) begin
            state_d      = S_IDLE;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d       = S_WR;
            avm_write_d   = 1'b1;
            avm_address_d = dst_ptr_q;
          end
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          idx_d       = idx_q + CNT_ONE;
          kidx_d      = (32'(kidx_q) == KEY_WORDS - 1) ? '0 : kidx_q + KI_ONE;
          src_ptr_d   = src_ptr_q + 32'd4;
          dst_ptr_d   = dst_ptr_q + 32'd4;
          // A pending abort wins over completion of the last word: DONE stays 0.
          if (abort_now) begin
            state_d      = S_IDLE;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
          end else if (idx_q + CNT_ONE == num_q) begin
            state_d = S_FIN;
          end else begin
            state_d       = S_RD;
            avm_read_d    = 1'b1;
            avm_address_d = src_ptr_q + 32'd4;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      for (int unsigned i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      num_q           <= '0;
      idx_q           <= '0;
      kidx_q          <= '0;
      src_ptr_q       <= '0;
      dst_ptr_q       <= '0;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      abort_pend_q    <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      key_q           <= key_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      num_q           <= num_d;
      idx_q           <= idx_d;
      kidx_q          <= kidx_d;
      src_ptr_q       <= src_ptr_d;
      dst_ptr_q       <= dst_ptr_d;
      irq_en_q        <= irq_en_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
      abort_pend_q    <= abort_pend_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  always_comb begin
    avs_readdata = '0;
    for (int unsigned i = 0; i < KEY_WORDS; i++)
      if (reg_num == i) avs_readdata = key_q[i];
    if (reg_num == IDX_SRC) avs_readdata = src_q;
    if (reg_num == IDX_DST) avs_readdata = dst_q;
    if (reg_num == IDX_NUM) avs_readdata = 32'(num_q);
    if (reg_num == IDX_CTRL)
      avs_readdata = {cnt32[15:0], 11'b0, aborted_q, 1'b0, done_q, irq_en_q, busy};
  end

endmodule

// File: tb/tb_avalon_xor_dma.sv
module tb_avalon_xor_dma;

  localparam int R_SRC = 4, R_DST = 5, R_NUM = 6, R_CTRL = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [4:0]  avs_address;
  logic [31:0] avs_readdata;
  logic        avm_read, avm_write;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic        irq;

  avalon_xor_dma #(.KEY_WORDS(4), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_address(avs_address),
    .avs_readdata(avs_readdata),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bus slave: 256-word memory, address bits [9:2]
  logic [31:0] mem [256];
  logic        wait_rand;   // 1: random stalls, 0: wait_force drives waitrequest
  logic        wait_force;
  logic        rnd_bit = 1'b0;
  int          n_acc = 0;
  logic [31:0] rd_log [$];

  assign avm_readdata    = mem[avm_address[9:2]];
  assign avm_waitrequest = wait_rand ? rnd_bit : wait_force;

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic        p_valid = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_wait = 1'b0;
  logic [31:0] p_addr = '0, p_data = '0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (avm_read || avm_write) chk("rw_overlap", 32'(avm_read & avm_write), 32'd0);
      if (p_valid && p_wait && (p_rd || p_wr)) begin
        chk("stall_req", {30'b0, avm_read, avm_write}, {30'b0, p_rd, p_wr});
        chk("stall_addr", avm_address, p_addr);
        if (p_wr) chk("stall_data", avm_writedata, p_data);
      end
      if (avm_read && !avm_waitrequest) begin
        n_acc++;
        rd_log.push_back(avm_address);
      end
      if (avm_write && !avm_waitrequest) begin
        n_acc++;
        mem[avm_address[9:2]] = avm_writedata;
      end
    end
    p_valid = reset_n;
    p_rd    = avm_read;
    p_wr    = avm_write;
    p_addr  = avm_address;
    p_data  = avm_writedata;
    p_wait  = avm_waitrequest;
  end

  task automatic avs_wr(input int idx, input logic [31:0] data);
    @(negedge clk);
    avs_write     = 1'b1;
    avs_address   = 5'(idx * 4);
    avs_writedata = data;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    avs_address = 5'(idx * 4);
    #1;
    v = avs_readdata;
  endtask

  task automatic wait_end(input string tag, input int limit, output int cyc);
    logic [31:0] s;
    bit hit;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(negedge clk);
      cyc++;
      rd_reg(R_CTRL, s);
      if (s[2] || s[4]) hit = 1;
    end
    chk({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] key [4];
    logic [31:0] exp1 [6];
    logic [31:0] rd_exp [4];
    int cyc, acc0;
    bit hit;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset_n = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_address = '0;
    wait_rand = 1'b0; wait_force = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    for (int r = 0; r < 8; r++) begin rd_reg(r, v); chk($sformatf("reset_reg%0d", r), v, 32'd0); end
    chk("reset_avm_rd", 32'(avm_read), 32'd0);
    chk("reset_avm_wr", 32'(avm_write), 32'd0);
    chk("reset_avm_addr", avm_address, 32'd0);
    chk("reset_avm_wdata", avm_writedata, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // T1: basic copy, no stalls
    key = '{32'd1, 32'd2, 32'd4, 32'd8};
    exp1 = '{32'h1, 32'h3, 32'h6, 32'hB, 32'h5, 32'h7};
    for (int i = 0; i < 6; i++) mem[8'h40 + i] = 32'(i);
    for (int i = 0; i < 4; i++) avs_wr(i, key[i]);
    avs_wr(R_SRC, 32'h100); avs_wr(R_DST, 32'h200); avs_wr(R_NUM, 32'd6);
    acc0 = n_acc;
    avs_wr(R_CTRL, 32'h1);
    chk("t1_first_rd", 32'(avm_read), 32'd1);
    chk("t1_first_addr", avm_address, 32'h100);
    wait_end("t1", 100, cyc);
    chk("t1_cycles", 32'(cyc), 32'd13);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_dst%0d", i), mem[8'h80 + i], exp1[i]);
    chk("t1_bus_xfers", 32'(n_acc - acc0), 32'd12);
    rd_reg(R_CTRL, v); chk("t1_ctrl", v, 32'h0006_0004);
    chk("t1_irq_masked", 32'(irq), 32'd0);
    avs_wr(R_CTRL, 32'h2);
    chk("t1_irq_en_late", 32'(irq), 32'd1);

    // T2: NUM=0 completes without bus traffic
    avs_wr(R_NUM, 32'd0);
    acc0 = n_acc;
    avs_wr(R_CTRL, 32'h3);
    @(negedge clk);
    rd_reg(R_CTRL, v); chk("t2_ctrl", v, 32'h0000_0006);
    chk("t2_irq", 32'(irq), 32'd1);
    chk("t2_no_traffic", 32'(n_acc - acc0), 32'd0);
    avs_wr(R_CTRL, 32'h6);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    rd_reg(R_CTRL, v); chk("t2_ctrl_clr", v, 32'h0000_0002);

    // T3: 16 words with random stalls
    key = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h1234_5678, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) avs_wr(i, key[i]);
    for (int i = 0; i < 16; i++) mem[8'h40 + i] = 32'h0101_0101 * 32'(i + 1);
    avs_wr(R_DST, 32'h280); avs_wr(R_NUM, 32'd16);
    wait_rand = 1'b1;
    avs_wr(R_CTRL, 32'h1);
    wait_end("t3", 1000, cyc);
    wait_rand = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_dst%0d", i), mem[8'hA0 + i], (32'h0101_0101 * 32'(i + 1)) ^ key[i % 4]);
    rd_reg(R_CTRL, v); chk("t3_ctrl", v, 32'h0010_0004);

    // T4: abort while write of word 3 (of 10) is stalled
    avs_wr(R_DST, 32'h300); avs_wr(R_NUM, 32'd10);
    rd_log.delete();
    avs_wr(R_CTRL, 32'h3);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (avm_write && avm_address == 32'h30C) begin wait_force = 1'b1; hit = 1; end
    end
    chk("t4_reach_wr3", 32'(hit), 32'd1);
    avs_wr(R_CTRL, 32'hA);
    repeat (2) @(negedge clk);
    chk("t4_wr3_held", 32'(avm_write), 32'd1);
    wait_force = 1'b0;
    wait_end("t4", 50, cyc);
    repeat (3) @(negedge clk);
    rd_reg(R_CTRL, v); chk("t4_ctrl", v, 32'h0004_0012);
    chk("t4_irq", 32'(irq), 32'd0);
    chk("t4_reads", 32'(rd_log.size()), 32'd4);
    chk("t4_dst3", mem[8'hC3], 32'h0404_0404 ^ key[3]);
    chk("t4_dst4_untouched", mem[8'hC4], 32'd0);

    // T5: source address wraps; config writes ignored while busy
    key = '{32'd1, 32'd2, 32'd4, 32'd8};
    for (int i = 0; i < 4; i++) avs_wr(i, key[i]);
    mem[8'hFE] = 32'h10; mem[8'hFF] = 32'h20; mem[8'h00] = 32'h30; mem[8'h01] = 32'h40;
    avs_wr(R_SRC, 32'hFFFF_FFF8); avs_wr(R_DST, 32'h340); avs_wr(R_NUM, 32'd4);
    rd_log.delete();
    avs_wr(R_CTRL, 32'h1);
    avs_wr(0, 32'hDEAD_BEEF);
    avs_wr(R_SRC, 32'h1234);
    wait_end("t5", 100, cyc);
    rd_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    chk("t5_nreads", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rd_log.size()) chk($sformatf("t5_rdaddr%0d", i), rd_log[i], rd_exp[i]);
    chk("t5_dst0", mem[8'hD0], 32'h11);
    chk("t5_dst3", mem[8'hD3], 32'h48);
    rd_reg(0, v); chk("t5_key0_kept", v, 32'd1);
    rd_reg(R_SRC, v); chk("t5_src_kept", v, 32'hFFFF_FFF8);
    rd_reg(R_CTRL, v); chk("t5_ctrl", v, 32'h0004_0004);

    // T6: reset while a read is stalled
    avs_wr(R_SRC, 32'h100); avs_wr(R_DST, 32'h380); avs_wr(R_NUM, 32'd2);
    wait_force = 1'b1;
    avs_wr(R_CTRL, 32'h3);
    chk("t6_rd_active", 32'(avm_read), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_rd_dropped", 32'(avm_read), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    for (int r = 0; r < 8; r++) begin rd_reg(r, v); chk($sformatf("t6_reg%0d", r), v, 32'd0); end
    wait_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle_rd", 32'(avm_read), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
